disparity_hole_fill: RTL and testbench
======================================

DISPARITY_HOLE_FILL -- requirements
Module: disparity_hole_fill

Interface
REQ-001 Parameter WIDTH, default 9: disparity bit width; equals the median-filter stage WIDTH.
REQ-002 Parameter INVALID, default {WIDTH{1'b1}}: disparity code that marks an invalid pixel (hole).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 clken  input  1  global advance enable; when low, no state, counter or output changes.
REQ-006 width  input  11  pixels per row, legal range 2..2047; sampled only while idle at row start.
REQ-007 valid_in  input  1  disp_in carries a pixel.
REQ-008 disp_in  input  WIDTH  raw disparity, raster order.
REQ-009 ready_in  output  1  block accepts a pixel this cycle; transfer = valid_in & ready_in & clken.
REQ-010 disp_hole  output  WIDTH  filled disparity, feeds the median filter.
REQ-011 valid_final_hole  output  1  disp_hole valid, one-cycle pulse per pixel.
REQ-012 row_end  output  1  asserted with the last output pixel of each row.

Function
REQ-013 States SHALL be PASS, HOLD and DRAIN; ready_in = (state != DRAIN).
REQ-014 Column counter SHALL increment per accepted pixel and wrap from width-1 to 0; the last-column flag derives from it.
REQ-015 left_val SHALL hold the most recent valid disparity in the current row; left_ok SHALL be cleared at row start.
REQ-016 PASS, valid pixel accepted: registered to disp_hole with valid_final_hole=1 at the next edge (latency 1); left_val is updated.
REQ-017 PASS, INVALID pixel accepted: run_len=1, go to HOLD, no output.
REQ-018 HOLD, INVALID pixel accepted: run_len+1 (11 bits, cannot overflow because run_len <= width); no output.
REQ-019 HOLD, valid pixel P accepted: fill = min(left_val,P) if left_ok, otherwise P; store P; go to DRAIN.
REQ-020 DRAIN SHALL emit fill for run_len consecutive clken cycles, then emit P, then return to PASS; pixel order out equals pixel order in.
REQ-021 Row ends while in HOLD (last pixel INVALID): fill = left_val if left_ok, otherwise 0; DRAIN emits run_len fills with no trailing P.
REQ-022 row_end SHALL accompany the output corresponding to column width-1.
REQ-023 A fully invalid row SHALL output width zeros.
REQ-024 Holes SHALL never span rows; left_ok and run_len clear at each row boundary.
REQ-025 clken low in any state: outputs hold their values, but valid_final_hole is forced low for that cycle, and no pixel is accepted.
REQ-026 No output value SHALL equal INVALID.

Reset
REQ-027 Asynchronous reset assertion: state=PASS, column=0, run_len=0, left_ok=0, left_val=0, disp_hole=0, valid_final_hole=0, row_end=0, ready_in=1.
REQ-028 Reset mid-DRAIN SHALL discard the pending run and stored P; no partial output after release.
REQ-029 Reset release SHALL be synchronised externally; first acceptance may occur on the first edge after release.

Structure
REQ-030 State encoding and the INVALID default SHALL live in the shared stereo package, alongside the WIDTH default used by the median-filter stage.
REQ-031 One sub-module, hole_run_counter, SHALL contain the column counter, run_len counter and row-boundary detection.
REQ-032 disp_hole and valid_final_hole SHALL be registered outputs that connect directly to the median-filter inputs.

Verification
REQ-033 width=8, row 5,5,5,5,5,5,5,5 continuous -> same 8 values, latency 1, row_end on 8th, ready_in always 1.
REQ-034 width=8, row 10,INV,INV,INV,4,7,7,7 -> output 10,4,4,4,4,7,7,7; ready_in low for exactly 3 cycles after 4 is accepted.
REQ-035 width=6, row INV,INV,9,9,INV,INV -> 9,9,9,9,9,9; row_end on last; next row starts with left_ok=0.
REQ-036 width=4, row all INV -> 0,0,0,0 with row_end on 4th; next row 3,3,3,3 passes unchanged.
REQ-037 Random clken/valid_in toggling with 20% holes over 100 rows of width 37 -> output count per row = 37; values match the reference model; no INVALID output.
REQ-038 rst asserted during DRAIN with run_len=5 -> outputs zero immediately; after release, new row 1,2,3,4 (width=4) outputs 1,2,3,4.

Source files
------------

// File: rtl/disparity_hole_fill_pkg.sv
// Shared stereo-pipeline definitions: disparity width, hole code,
// hole-fill FSM states and run-counter operations.
package disparity_hole_fill_pkg;

    localparam int DISP_W = 9;
    localparam logic [31:0] INVALID_ALL = '1;
    localparam int COL_W = 11;

    typedef enum logic [1:0] {
        PASS  = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } hf_state_e;

    typedef enum logic [2:0] {
        RUN_KEEP = 3'd0,
        RUN_ONE  = 3'd1,
        RUN_INC  = 3'd2,
        RUN_DEC  = 3'd3,
        RUN_CLR  = 3'd4
    } run_op_e;

endpackage

// File: rtl/disparity_hole_fill_if.sv
// Pixel stream into the hole filler and filled stream out
// toward the median filter.
interface disparity_hole_fill_if
    import disparity_hole_fill_pkg::*;
#(
    parameter int WIDTH = DISP_W
);

    logic             valid_in;
    logic [WIDTH-1:0] disp_in;
    logic             ready_in;
    logic [WIDTH-1:0] disp_hole;
    logic             valid_final_hole;
    logic             row_end;

    modport master (
        output valid_in,
        output disp_in,
        input  ready_in,
        input  disp_hole,
        input  valid_final_hole,
        input  row_end
    );

    modport slave (
        input  valid_in,
        input  disp_in,
        output ready_in,
        output disp_hole,
        output valid_final_hole,
        output row_end
    );

endinterface

// File: rtl/disparity_hole_fill_hole_run_counter.sv
// Column position, row-width capture and hole-run length for
// the hole filler; the row width is latched on a row's first pixel.
module hole_run_counter
    import disparity_hole_fill_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clken,
    input  logic             accept_i,
    input  logic [COL_W-1:0] width_i,
    input  run_op_e          run_op_i,
    output logic             last_col_o,
    output logic [COL_W-1:0] run_len_o
);

    logic [COL_W-1:0] col_q, col_d;
    logic [COL_W-1:0] wid_q, wid_d;
    logic [COL_W-1:0] run_q, run_d;
    logic [COL_W-1:0] w_eff;
    logic             last;

    // At column 0 the live width input governs the new row
    assign w_eff = (col_q == '0) ? width_i : wid_q;
    assign last  = (col_q == w_eff - 11'd1);

    always_comb begin
        col_d = col_q;
        wid_d = wid_q;
        if (accept_i) begin
            if (col_q == '0) begin
                wid_d = width_i;
            end
            col_d = last ? '0 : col_q + 11'd1;
        end
    end

    always_comb begin
        run_d = run_q;
        unique case (run_op_i)
            RUN_KEEP: run_d = run_q;
            RUN_ONE:  run_d = 11'd1;
            RUN_INC:  run_d = run_q + 11'd1;
            RUN_DEC:  run_d = run_q - 11'd1;
            RUN_CLR:  run_d = '0;
            default:  run_d = run_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q <= '0;
            wid_q <= '0;
            run_q <= '0;
        end else if (clken) begin
            col_q <= col_d;
            wid_q <= wid_d;
            run_q <= run_d;
        end
    end

    assign last_col_o = last;
    assign run_len_o  = run_q;

endmodule

// File: rtl/disparity_hole_fill.sv
// Replaces runs of invalid disparities with the smaller of the
// neighbouring valid values, keeping raster order and row framing.
module disparity_hole_fill
    import disparity_hole_fill_pkg::*;
#(
    parameter int               WIDTH   = DISP_W,
    parameter logic [WIDTH-1:0] INVALID = INVALID_ALL[WIDTH-1:0]
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clken,
    input  logic [COL_W-1:0]     width,
    disparity_hole_fill_if.slave s
);

    hf_state_e        state_q, state_d;
    logic [WIDTH-1:0] left_val_q, left_val_d;
    logic             left_ok_q, left_ok_d;
    logic [WIDTH-1:0] fill_q, fill_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic             has_p_q, has_p_d;
    logic             rend_q, rend_d;
    logic [WIDTH-1:0] disp_q, disp_d;
    logic             vout_q, vout_d;
    logic             row_end_q, row_end_d;

    logic             ready;
    logic             accept;
    logic             inv;
    logic             last;
    logic [COL_W-1:0] run_len;
    run_op_e          run_op;
    logic [WIDTH-1:0] left_fill;
    logic [WIDTH-1:0] min_fill;

    assign ready  = (state_q != DRAIN);
    assign accept = s.valid_in & ready & clken;
    assign inv    = (s.disp_in == INVALID);

    assign left_fill = left_ok_q ? left_val_q : '0;
    assign min_fill  = (left_ok_q && (left_val_q < s.disp_in))
                     ? left_val_q : s.disp_in;

    hole_run_counter u_cnt (
        .clk        (clk),
        .rst        (rst),
        .clken      (clken),
        .accept_i   (accept),
        .width_i    (width),
        .run_op_i   (run_op),
        .last_col_o (last),
        .run_len_o  (run_len)
    );

    always_comb begin
        state_d    = state_q;
        left_val_d = left_val_q;
        left_ok_d  = left_ok_q;
        fill_d     = fill_q;
        p_d        = p_q;
        has_p_d    = has_p_q;
        rend_d     = rend_q;
        disp_d     = disp_q;
        vout_d     = 1'b0;
        row_end_d  = 1'b0;
        run_op     = RUN_KEEP;
        unique case (state_q)
            PASS: begin
                if (accept) begin
                    if (!inv) begin
                        disp_d     = s.disp_in;
                        vout_d     = 1'b1;
                        row_end_d  = last;
                        left_val_d = s.disp_in;
                        left_ok_d  = !last;
                    end else if (last) begin
                        disp_d    = left_fill;
                        vout_d    = 1'b1;
                        row_end_d = 1'b1;
                        left_ok_d = 1'b0;
                        run_op    = RUN_CLR;
                    end else begin
                        run_op  = RUN_ONE;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (accept) begin
                    if (inv && !last) begin
                        run_op = RUN_INC;
                    end else begin
                        // First fill leaves now; DRAIN sends the rest
                        vout_d    = 1'b1;
                        state_d   = DRAIN;
                        left_ok_d = !inv && !last;
                        rend_d    = last;
                        if (inv) begin
                            disp_d  = left_fill;
                            fill_d  = left_fill;
                            has_p_d = 1'b0;
                        end else begin
                            disp_d     = min_fill;
                            fill_d     = min_fill;
                            p_d        = s.disp_in;
                            has_p_d    = 1'b1;
                            left_val_d = s.disp_in;
                            run_op     = RUN_DEC;
                        end
                    end
                end
            end
            DRAIN: begin
                vout_d = 1'b1;
                if (run_len != '0) begin
                    disp_d = fill_q;
                    run_op = RUN_DEC;
                    if (run_len == 11'd1 && !has_p_q) begin
                        row_end_d = rend_q;
                        state_d   = PASS;
                    end
                end else begin
                    disp_d    = p_q;
                    row_end_d = rend_q;
                    state_d   = PASS;
                end
            end
            default: state_d = PASS;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= PASS;
            left_val_q <= '0;
            left_ok_q  <= 1'b0;
            fill_q     <= '0;
            p_q        <= '0;
            has_p_q    <= 1'b0;
            rend_q     <= 1'b0;
            disp_q     <= '0;
            vout_q     <= 1'b0;
            row_end_q  <= 1'b0;
        end else if (clken) begin
            state_q    <= state_d;
            left_val_q <= left_val_d;
            left_ok_q  <= left_ok_d;
            fill_q     <= fill_d;
            p_q        <= p_d;
            has_p_q    <= has_p_d;
            rend_q     <= rend_d;
            disp_q     <= disp_d;
            vout_q     <= vout_d;
            row_end_q  <= row_end_d;
        end else begin
            vout_q <= 1'b0;
        end
    end

    assign s.ready_in         = ready;
    assign s.disp_hole        = disp_q;
    assign s.valid_final_hole = vout_q;
    assign s.row_end          = row_end_q;

endmodule

// File: tb/tb_disparity_hole_fill.sv
// Random and directed rows against a row-level hole-fill model,
// checked through an output scoreboard.
module tb_disparity_hole_fill;

    localparam int INV = 511;

    typedef struct {
        int val;
        bit rend;
        int w;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        clken;
    logic [10:0] width;

    disparity_hole_fill_if #(.WIDTH(9)) bus();

    disparity_hole_fill #(.WIDTH(9)) dut (
        .clk   (clk),
        .rst   (rst_n),
        .clken (clken),
        .width (width),
        .s     (bus)
    );

    exp_t q[$];
    int   n_chk;
    int   n_fail;
    int   rlow;
    int   out_cnt;
    bit   mon_en;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int got, input int req);
        n_chk++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s got=%0d required=%0d", nm, got, req);
        end
    endtask

    // Expected output of one whole row from the fill rules
    task automatic model_row(input int w, input int px[$]);
        int   left;
        bit   lok;
        int   run;
        int   f;
        exp_t e;
        left = 0;
        lok  = 0;
        run  = 0;
        e.rend = 0;
        e.w    = w;
        foreach (px[i]) begin
            if (px[i] == INV) begin
                run++;
            end else begin
                f = (lok && left < px[i]) ? left : px[i];
                e.val = f;
                repeat (run) q.push_back(e);
                e.val = px[i];
                q.push_back(e);
                run  = 0;
                left = px[i];
                lok  = 1;
            end
        end
        e.val = lok ? left : 0;
        repeat (run) q.push_back(e);
        q[q.size()-1].rend = 1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            out_cnt = 0;
        end else if (mon_en) begin
            if (!bus.ready_in) rlow++;
            if (bus.valid_final_hole) begin
                if (q.size() == 0) begin
                    check("unexpected_out", int'(bus.disp_hole), -1);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    out_cnt++;
                    check("disp_hole", int'(bus.disp_hole), e.val);
                    check("row_end", int'(bus.row_end), int'(e.rend));
                    check("not_invalid",
                          int'(bus.disp_hole == 9'h1ff), 0);
                    if (e.rend) begin
                        check("row_count", out_cnt, e.w);
                        out_cnt = 0;
                    end
                end
            end
        end
    end

    task automatic send_px(input int v, input bit rnd);
        bit done;
        int guard;
        done  = 0;
        guard = 0;
        while (!done) begin
            clken = rnd ? ($urandom_range(0, 99) < 80) : 1'b1;
            bus.valid_in = rnd ? ($urandom_range(0, 99) < 80) : 1'b1;
            bus.disp_in  = 9'(v);
            done = bus.valid_in && bus.ready_in && clken;
            @(negedge clk);
            guard++;
            if (guard > 1000) begin
                $display("FAIL accept_timeout got=%0d required=0", guard);
                $fatal(1, "stalled");
            end
        end
        bus.valid_in = 1'b0;
        clken        = 1'b1;
    endtask

    task automatic send_row(input int px[$], input bit rnd, input bit push);
        if (push) model_row(int'(width), px);
        foreach (px[i]) send_px(px[i], rnd);
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (q.size() != 0 && g < 2000) begin
            @(negedge clk);
            g++;
        end
        check("drain_left", q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int px[$];
        n_chk        = 0;
        n_fail       = 0;
        rlow         = 0;
        out_cnt      = 0;
        mon_en       = 1;
        rst_n        = 1'b0;
        clken        = 1'b0;
        width        = 11'd8;
        bus.valid_in = 1'b0;
        bus.disp_in  = '0;
        repeat (2) @(negedge clk);
        check("rst_disp", int'(bus.disp_hole), 0);
        check("rst_valid", int'(bus.valid_final_hole), 0);
        check("rst_row_end", int'(bus.row_end), 0);
        check("rst_ready", int'(bus.ready_in), 1);
        rst_n = 1'b1;
        clken = 1'b1;
        @(negedge clk);

        rlow = 0;
        px = '{5, 5, 5, 5, 5, 5, 5, 5};
        send_row(px, 0, 1);
        wait_drain();
        check("ready_low_flat", rlow, 0);

        rlow = 0;
        px = '{10, INV, INV, INV, 4, 7, 7, 7};
        send_row(px, 0, 1);
        wait_drain();
        check("ready_low_hole", rlow, 3);

        width = 11'd6;
        px = '{INV, INV, 9, 9, INV, INV};
        send_row(px, 0, 1);
        px = '{INV, INV, 20, 1, 1, 1};
        send_row(px, 0, 1);
        wait_drain();

        width = 11'd4;
        px = '{INV, INV, INV, INV};
        send_row(px, 0, 1);
        px = '{3, 3, 3, 3};
        send_row(px, 0, 1);
        wait_drain();

        // Reset lands while a five-pixel hole is draining
        width  = 11'd8;
        mon_en = 0;
        px = '{1, INV, INV, INV, INV, INV, 2};
        send_row(px, 0, 0);
        check("pre_rst_busy", int'(bus.ready_in), 0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_disp", int'(bus.disp_hole), 0);
        check("mid_rst_valid", int'(bus.valid_final_hole), 0);
        check("mid_rst_row_end", int'(bus.row_end), 0);
        check("mid_rst_ready", int'(bus.ready_in), 1);
        q.delete();
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1;
        width  = 11'd4;
        repeat (3) @(negedge clk);
        px = '{1, 2, 3, 4};
        send_row(px, 0, 1);
        wait_drain();

        width = 11'd37;
        for (int r = 0; r < 100; r++) begin
            px.delete();
            for (int c = 0; c < 37; c++) begin
                if ($urandom_range(0, 99) < 20) px.push_back(INV);
                else px.push_back(int'($urandom_range(0, 510)));
            end
            send_row(px, 1, 1);
        end
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
